irq_arbiter: RTL and testbench

Priority interrupt arbiter that shares the CPU's single interrupt request between the SoC's interrupt sources: keyboard input flag, SPI receive-complete, display output flag, and the external interrupt pin. Sits between the peripherals and `cpu0`. Responsibilities:
- latches and masks requests;
- presents one registered request to the CPU when its IEN flag is set;
- on the CPU's interrupt-cycle acknowledge, selects and holds the winning source ID for the service routine to read over an IO port;
- releases on end-of-interrupt.

---
 rtl/irq_pkg.sv | 16 +
 rtl/irq_sync_edge.sv | 62 ++++++
 rtl/irq_arbiter.sv | 127 ++++++++++++
 tb/tb_irq_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt arbiter slice.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } irq_state_t;

  localparam int unsigned SRC_KBD      = 0;
  localparam int unsigned SRC_SPI      = 1;
  localparam int unsigned SRC_DISP     = 2;
  localparam int unsigned SRC_EXT      = 3;
  localparam int unsigned NSRC_DEFAULT = 4;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt source: optional 2-flop synchronizer, then either a registered
// level follower or a rising-edge detector feeding a sticky pending bit.
module irq_sync_edge #(
  parameter bit IsEdge = 1'b0,
  parameter bit IsSync = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic clr_i,
  output logic pend_o
);

  logic src_s;
  logic pend_q, pend_d;

  if (IsSync) begin : g_sync
    logic [1:0] sync_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[0], src_i};
      end
    end
    assign src_s = sync_q[1];
  end else begin : g_nosync
    assign src_s = src_i;
  end

  if (IsEdge) begin : g_edge
    logic prev_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        prev_q <= 1'b0;
      end else begin
        prev_q <= src_s;
      end
    end
    // A new edge in the same cycle as a clear keeps the bit pending.
    always_comb begin
      pend_d = pend_q;
      if (clr_i) pend_d = 1'b0;
      if (src_s && !prev_q) pend_d = 1'b1;
    end
  end else begin : g_level
    logic unused_clr;
    assign unused_clr = clr_i;
    assign pend_d = src_s;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/irq_arbiter.sv
// Priority interrupt arbiter: masks pending sources, raises one registered
// request to the CPU, latches the winner on acknowledge and releases on EOI.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int unsigned     NSRC        = NSRC_DEFAULT,
  parameter logic [NSRC-1:0] EDGE_MASK   = 4'b1010,
  parameter logic [NSRC-1:0] SYNC_MASK   = 4'b1000,
  parameter bit              ROUND_ROBIN = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NSRC-1:0]         src_in,
  input  logic                    ien,
  input  logic                    irq_ack,
  input  logic                    eoi,
  input  logic                    mask_we,
  input  logic [NSRC-1:0]         mask_wdata,
  output logic                    irq_o,
  output logic [$clog2(NSRC)-1:0] src_id,
  output logic                    src_valid,
  output logic [NSRC-1:0]         pend_o,
  output logic [NSRC-1:0]         mask_o
);

  localparam int unsigned IdW = $clog2(NSRC);

  irq_state_t      state_q, state_d;
  logic [NSRC-1:0] pend, elig, clr;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [IdW-1:0]  src_id_q, src_id_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]  start, winner;
  logic            found;
  logic            irq_q;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    irq_sync_edge #(
      .IsEdge (EDGE_MASK[i]),
      .IsSync (SYNC_MASK[i])
    ) u_src (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .src_i  (src_in[i]),
      .clr_i  (clr[i]),
      .pend_o (pend[i])
    );
  end

  // mask_q is the pre-write value, so a write coinciding with ack is not seen here.
  assign elig  = pend & mask_q;
  assign start = ROUND_ROBIN ? rr_ptr_q : '0;

  always_comb begin
    int unsigned idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      idx = i + 32'(start);
      if (idx >= NSRC) idx = idx - NSRC;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = IdW'(idx);
      end
    end
  end

  assign mask_d = mask_we ? mask_wdata : mask_q;

  always_comb begin
    state_d  = state_q;
    src_id_d = src_id_q;
    rr_ptr_d = rr_ptr_q;
    clr      = '0;
    unique case (state_q)
      IDLE: begin
        if ((elig != '0) && ien) state_d = REQ;
      end
      REQ: begin
        if (irq_ack) begin
          state_d  = SERVICE;
          src_id_d = winner;
        end else if ((elig == '0) || !ien) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_d       = IDLE;
          clr[src_id_q] = 1'b1;
          rr_ptr_d      = (src_id_q == IdW'(NSRC - 1)) ? '0 : src_id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q   <= '0;
      src_id_q <= '0;
      rr_ptr_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      src_id_q <= src_id_d;
      rr_ptr_q <= rr_ptr_d;
      irq_q    <= (state_d == REQ);
    end
  end

  assign irq_o     = irq_q;
  assign src_id    = src_id_q;
  assign src_valid = (state_q == SERVICE);
  assign pend_o    = pend;
  assign mask_o    = mask_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: fixed-priority and round-robin instances share stimulus.
module tb_irq_arbiter;
  import irq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] src_in;
  logic       ien, irq_ack, eoi, mask_we;
  logic [3:0] mask_wdata;

  logic       fx_irq, fx_valid, rr_irq, rr_valid;
  logic [1:0] fx_id, rr_id;
  logic [3:0] fx_pend, fx_mask, rr_pend, rr_mask;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  irq_arbiter #(
    .NSRC        (4),
    .EDGE_MASK   (4'b1010),
    .SYNC_MASK   (4'b1000),
    .ROUND_ROBIN (1'b0)
  ) dut_fx (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_in     (src_in),
    .ien        (ien),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_o      (fx_irq),
    .src_id     (fx_id),
    .src_valid  (fx_valid),
    .pend_o     (fx_pend),
    .mask_o     (fx_mask)
  );

  irq_arbiter #(
    .NSRC        (4),
    .EDGE_MASK   (4'b1010),
    .SYNC_MASK   (4'b1000),
    .ROUND_ROBIN (1'b1)
  ) dut_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_in     (src_in),
    .ien        (ien),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_o      (rr_irq),
    .src_id     (rr_id),
    .src_valid  (rr_valid),
    .pend_o     (rr_pend),
    .mask_o     (rr_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_sb(input string tag, input logic [1:0] got);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %0d expected <scoreboard empty>", tag, got);
    end else begin
      check(tag, 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    rst_n = 1'b1; src_in = '0; ien = 1'b0; irq_ack = 1'b0; eoi = 1'b0;
    mask_we = 1'b0; mask_wdata = '0;
    #2 rst_n = 1'b0;
    tick(); tick();
    check("rst irq", 32'(fx_irq), 0);
    check("rst id", 32'(fx_id), 0);
    check("rst valid", 32'(fx_valid), 0);
    check("rst pend", 32'(fx_pend), 0);
    check("rst mask", 32'(fx_mask), 0);
    rst_n = 1'b1;
    tick();

    // Reset and mask: synchronized edge source 3
    mask_we = 1'b1; mask_wdata = 4'b1111; ien = 1'b1;
    tick();
    mask_we = 1'b0;
    check("mask write", 32'(fx_mask), 32'hf);
    src_in[SRC_EXT] = 1'b1;
    tick();                      // edge k
    src_in[SRC_EXT] = 1'b0;
    tick();                      // k+1
    check("ext pend k+1", 32'(fx_pend), 0);
    tick();                      // k+2
    check("ext pend k+2", 32'(fx_pend), 32'h8);
    check("ext irq k+2", 32'(fx_irq), 0);
    tick();                      // k+3
    check("ext irq k+3", 32'(fx_irq), 1);
    irq_ack = 1'b1; exp_q.push_back(3);
    tick();
    irq_ack = 1'b0;
    check_sb("ext id", fx_id);
    check("ext valid", 32'(fx_valid), 1);
    check("ext irq after ack", 32'(fx_irq), 0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("ext eoi valid", 32'(fx_valid), 0);
    check("ext eoi pend", 32'(fx_pend), 0);

    // Fixed priority between level sources 0 and 2
    src_in[SRC_KBD] = 1'b1; src_in[SRC_DISP] = 1'b1;
    tick(); tick();
    check("fp irq", 32'(fx_irq), 1);
    irq_ack = 1'b1; exp_q.push_back(0);
    tick();
    irq_ack = 1'b0;
    check_sb("fp id first", fx_id);
    src_in[SRC_KBD] = 1'b0;
    tick();
    check("level drop keeps service", 32'(fx_valid), 1);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("fp eoi valid", 32'(fx_valid), 0);
    check("fp irq at m", 32'(fx_irq), 0);
    tick();
    check("fp irq at m+1", 32'(fx_irq), 1);
    irq_ack = 1'b1; exp_q.push_back(2);
    tick();
    irq_ack = 1'b0;
    check_sb("fp id second", fx_id);
    src_in[SRC_DISP] = 1'b0; eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    check("fp idle irq", 32'(fx_irq), 0);

    // Masking, stray ack, IEN withdrawal, mask write coinciding with ack
    mask_we = 1'b1; mask_wdata = 4'b0001;
    tick();
    mask_we = 1'b0;
    src_in[SRC_SPI] = 1'b1;
    tick();
    src_in[SRC_SPI] = 1'b0;
    tick(); tick();
    check("masked pend", 32'(fx_pend), 32'h2);
    check("masked irq", 32'(fx_irq), 0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("stray ack ignored", 32'(fx_valid), 0);
    mask_we = 1'b1; mask_wdata = 4'b0010;
    tick();
    mask_we = 1'b0;
    tick();
    check("unmasked irq", 32'(fx_irq), 1);
    ien = 1'b0;
    tick();
    check("ien withdraw irq", 32'(fx_irq), 0);
    tick();
    check("ien withdraw stays", 32'(fx_irq), 0);
    ien = 1'b1;
    tick();
    check("ien reraise", 32'(fx_irq), 1);
    irq_ack = 1'b1; mask_we = 1'b1; mask_wdata = 4'b0000; exp_q.push_back(1);
    tick();
    irq_ack = 1'b0; mask_we = 1'b0;
    check_sb("ack old mask id", fx_id);
    check("ack old mask valid", 32'(fx_valid), 1);
    check("mask cleared", 32'(fx_mask), 0);
    tick();
    check("mask no abort", 32'(fx_valid), 1);
    mask_we = 1'b1; mask_wdata = 4'b0010;
    tick();
    mask_we = 1'b0;

    // Edge set and EOI clear collide on source 1
    src_in[SRC_SPI] = 1'b1; eoi = 1'b1;
    tick();
    src_in[SRC_SPI] = 1'b0; eoi = 1'b0;
    check("collide pend", 32'(fx_pend), 32'h2);
    check("collide valid", 32'(fx_valid), 0);
    tick();
    check("collide irq", 32'(fx_irq), 1);
    irq_ack = 1'b1; exp_q.push_back(1);
    tick();
    irq_ack = 1'b0;
    check_sb("collide id", fx_id);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("collide cleared", 32'(fx_pend), 0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("stray eoi ignored", 32'(fx_valid), 0);

    // Asynchronous reset in the middle of SERVICE
    mask_we = 1'b1; mask_wdata = 4'b1111; src_in[SRC_SPI] = 1'b1; src_in[SRC_EXT] = 1'b1;
    tick();
    mask_we = 1'b0; src_in[SRC_SPI] = 1'b0; src_in[SRC_EXT] = 1'b0;
    tick();
    irq_ack = 1'b1; exp_q.push_back(1);
    tick();
    irq_ack = 1'b0;
    check_sb("pre-reset id", fx_id);
    #2 rst_n = 1'b0;
    #1;
    check("async rst valid", 32'(fx_valid), 0);
    check("async rst irq", 32'(fx_irq), 0);
    check("async rst pend", 32'(fx_pend), 0);
    check("async rst mask", 32'(fx_mask), 0);
    check("async rst id", 32'(fx_id), 0);
    check("async rst rr pend", 32'(rr_pend), 0);
    tick(); tick();
    rst_n = 1'b1;
    mask_we = 1'b1; mask_wdata = 4'b1111;
    tick();
    mask_we = 1'b0;
    check("rr mask after reset", 32'(rr_mask), 32'hf);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no spurious irq", 32'(fx_irq), 0);
    end

    // Round robin: keep all four pending and cycle through ack/eoi
    src_in = 4'b1111;
    tick();
    src_in = 4'b0101;
    tick(); tick(); tick();
    check("rr all pending", 32'(rr_pend), 32'hf);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int n = 0; n < 5; n++) begin
      for (int t = 0; t < 8 && !rr_irq; t++) tick();
      check("rr irq", 32'(rr_irq), 1);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      check_sb("rr order", rr_id);
      check("rr valid", 32'(rr_valid), 1);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      check("rr eoi valid", 32'(rr_valid), 0);
    end
    src_in = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
